// File: rtl/fetch_sequencer.sv
// fetch_sequencer: instruction fetch controller.
//   Owns the PC, drives a combinational instruction memory and buffers the
//   fetched {pc, inst} pairs in a 2-entry FIFO. Decode takes them over a
//   valid/ready handshake.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   start             begin/resume fetching (IDLE, HALTED)
//   halt_req          stop fetching, drain queue, then halt
//   redirect_valid    load redirect_pc, flush queue
//   redirect_pc       new PC
//   imem_addr         memory address (= PC register)
//   imem_inst         memory read data, same cycle
//   out_valid         head entry available
//   out_ready         decode accepts head
//   out_inst, out_pc  head entry
//   halted            high in HALTED
//   fetch_count       pushes since reset, saturating
module fetch_sequencer #(
  parameter int              ADDR_W   = 20,
  parameter int              INST_W   = 20,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              halt_req,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [INST_W-1:0] imem_inst,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [INST_W-1:0] out_inst,
  output logic [ADDR_W-1:0] out_pc,
  output logic              halted,
  output logic [15:0]       fetch_count
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_HALTED} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic [1:0]          cnt_q, cnt_d;
  logic [ADDR_W-1:0]   hd_pc_q, hd_pc_d, tl_pc_q, tl_pc_d;
  logic [INST_W-1:0]   hd_inst_q, hd_inst_d, tl_inst_q, tl_inst_d;
  logic [15:0]         fcnt_q, fcnt_d;

  logic fetch_en;
  logic pop, push;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // FSM: next state. Redirect outranks halt_req and start; DRAIN looks at the
  // post-update count so HALTED is entered on the same edge the queue empties.
  always_comb begin
    state_d = state_q;
    if (redirect_valid) begin
      if (state_q == S_DRAIN) state_d = S_HALTED;
    end else begin
      unique case (state_q)
        S_IDLE:   if (start)       state_d = S_RUN;
        S_RUN:    if (halt_req)    state_d = S_DRAIN;
        S_DRAIN:  if (cnt_d == 2'd0) state_d = S_HALTED;
        S_HALTED: if (start)       state_d = S_RUN;
        default:                   state_d = S_IDLE;
      endcase
    end
  end

  // FSM: outputs
  always_comb begin
    fetch_en = (state_q == S_RUN);
    halted   = (state_q == S_HALTED);
  end

  // ---------------------------------------------------------------------------
  // Handshake and fetch qualification
  // ---------------------------------------------------------------------------
  assign imem_addr   = pc_q;
  assign out_valid   = (cnt_q != 2'd0) & ~redirect_valid;
  assign out_inst    = hd_inst_q;
  assign out_pc      = hd_pc_q;
  assign fetch_count = fcnt_q;

  assign pop  = out_valid & out_ready;
  // A full queue can still accept a push when the head leaves this cycle.
  assign push = fetch_en & ~redirect_valid & ~halt_req & ((cnt_q != 2'd2) | pop);

  // ---------------------------------------------------------------------------
  // PC, FIFO and counter next-state
  // ---------------------------------------------------------------------------
  always_comb begin
    pc_d      = pc_q;
    cnt_d     = cnt_q;
    hd_pc_d   = hd_pc_q;
    hd_inst_d = hd_inst_q;
    tl_pc_d   = tl_pc_q;
    tl_inst_d = tl_inst_q;
    fcnt_d    = fcnt_q;

    if (redirect_valid) begin
      // Flush: entries keep their stale contents but count=0 hides them.
      pc_d  = redirect_pc;
      cnt_d = 2'd0;
    end else begin
      if (push) begin
        pc_d = pc_q + ADDR_W'(1);
        if (fcnt_q != 16'hFFFF) fcnt_d = fcnt_q + 16'd1;
      end
      unique case ({push, pop})
        2'b10: begin
          if (cnt_q == 2'd0) begin
            hd_pc_d   = pc_q;
            hd_inst_d = imem_inst;
          end else begin
            tl_pc_d   = pc_q;
            tl_inst_d = imem_inst;
          end
          cnt_d = cnt_q + 2'd1;
        end
        2'b01: begin
          hd_pc_d   = tl_pc_q;
          hd_inst_d = tl_inst_q;
          cnt_d     = cnt_q - 2'd1;
        end
        2'b11: begin
          // Count unchanged; the new entry lands behind whatever remains.
          if (cnt_q == 2'd1) begin
            hd_pc_d   = pc_q;
            hd_inst_d = imem_inst;
          end else begin
            hd_pc_d   = tl_pc_q;
            hd_inst_d = tl_inst_q;
            tl_pc_d   = pc_q;
            tl_inst_d = imem_inst;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q      <= RESET_PC;
      cnt_q     <= 2'd0;
      hd_pc_q   <= '0;
      hd_inst_q <= '0;
      tl_pc_q   <= '0;
      tl_inst_q <= '0;
      fcnt_q    <= 16'd0;
    end else begin
      pc_q      <= pc_d;
      cnt_q     <= cnt_d;
      hd_pc_q   <= hd_pc_d;
      hd_inst_q <= hd_inst_d;
      tl_pc_q   <= tl_pc_d;
      tl_inst_q <= tl_inst_d;
      fcnt_q    <= fcnt_d;
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: directed scenarios followed by random traffic,
// every cycle compared against a queue-based reference model.
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        halt_req = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [19:0] redirect_pc = '0;
  logic [19:0] imem_addr;
  logic [19:0] imem_inst;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [19:0] out_inst;
  logic [19:0] out_pc;
  logic        halted;
  logic [15:0] fetch_count;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  fetch_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .halt_req(halt_req),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_addr(imem_addr), .imem_inst(imem_inst),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_inst(out_inst), .out_pc(out_pc),
    .halted(halted), .fetch_count(fetch_count)
  );

  function automatic logic [19:0] mem(input logic [19:0] a);
    if (a < 20'd8)        return a;
    else if (a == 20'd16) return 20'h08180;
    else if (a == 20'd17) return 20'h02CB2;
    else                  return (a * 20'h009E3) ^ 20'h5A5A5;
  endfunction

  assign imem_inst = mem(imem_addr);

  // Reference model: mode 0 idle, 1 fetching, 2 draining, 3 halted.
  int          mode = 0;
  logic [19:0] mpc  = '0;
  logic [15:0] mfc  = '0;
  logic [39:0] mq[$];
  bit          armed = 1'b0;

  task automatic chk(input string tag, input logic [39:0] obs, input logic [39:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_step();
    bit v, p, pu;
    if (rst) begin
      mode = 0; mpc = '0; mfc = '0; mq.delete();
    end else if (redirect_valid) begin
      mpc = redirect_pc;
      mq.delete();
      if (mode == 2) mode = 3;
    end else begin
      v  = mq.size() > 0;
      p  = v && out_ready;
      pu = (mode == 1) && !halt_req && (mq.size() < 2 || p);
      if (p) void'(mq.pop_front());
      if (pu) begin
        mq.push_back({mpc, mem(mpc)});
        mpc = mpc + 20'd1;
        if (mfc != 16'hFFFF) mfc = mfc + 16'd1;
      end
      case (mode)
        0: if (start) mode = 1;
        1: if (halt_req) mode = 2;
        2: if (mq.size() == 0) mode = 3;
        3: if (start) mode = 1;
        default: mode = 0;
      endcase
    end
  endtask

  // One clock: check settled outputs against the model, advance model, take the edge.
  task automatic cycle();
    #1;
    if (armed) begin
      chk("imem_addr", {20'd0, imem_addr}, {20'd0, mpc});
      chk("out_valid", {39'd0, out_valid}, {39'd0, (mq.size() > 0) && !redirect_valid});
      if (mq.size() > 0) chk("head", {out_pc, out_inst}, mq[0]);
      chk("halted", {39'd0, halted}, {39'd0, mode == 3});
      chk("fetch_count", {24'd0, fetch_count}, {24'd0, mfc});
    end
    model_step();
    @(posedge clk);
    #1;
    armed = 1'b1;
  endtask

  task automatic do_reset();
    start = 0; halt_req = 0; redirect_valid = 0; out_ready = 0;
    rst = 1;
    cycle();
    rst = 0;
    chk("rst_out_pc", {20'd0, out_pc}, 40'd0);
    chk("rst_out_inst", {20'd0, out_inst}, 40'd0);
    chk("rst_valid", {39'd0, out_valid}, 40'd0);
  endtask

  // Reset, start, and let two pushes fill the queue with out_ready low.
  task automatic fill_two();
    do_reset();
    start = 1; cycle();
    start = 0; cycle(); cycle();
  endtask

  initial begin
    // 1. Flow
    do_reset();
    start = 1; out_ready = 1; cycle();
    start = 0;
    chk("flow_valid_n1", {39'd0, out_valid}, 40'd0);
    cycle();
    chk("flow_valid_n2", {39'd0, out_valid}, 40'd1);
    for (int k = 0; k < 8; k++) begin
      chk("flow_head", {out_pc, out_inst}, {k[19:0], k[19:0]});
      chk("flow_fcnt", {24'd0, fetch_count}, 40'(k + 1));
      cycle();
    end

    // 2. Backpressure
    fill_two();
    for (int k = 0; k < 3; k++) begin
      chk("bp_addr", {20'd0, imem_addr}, 40'd2);
      chk("bp_head", {out_pc, out_inst}, 40'd0);
      cycle();
    end
    out_ready = 1;
    for (int k = 0; k < 4; k++) begin
      chk("bp_drain", {out_pc, out_inst}, {k[19:0], k[19:0]});
      cycle();
    end

    // 3. Redirect
    fill_two();
    chk("rd_pre_pc", {20'd0, out_pc}, 40'd0);
    redirect_valid = 1; redirect_pc = 20'd16;
    #1 chk("rd_valid_low", {39'd0, out_valid}, 40'd0);
    cycle();
    redirect_valid = 0;
    chk("rd_flushed", {39'd0, out_valid}, 40'd0);
    cycle();
    out_ready = 1;
    chk("rd_head16", {out_pc, out_inst}, {20'd16, 20'h08180});
    cycle();
    chk("rd_head17", {out_pc, out_inst}, {20'd17, 20'h02CB2});
    cycle();

    // 4. Halt / drain
    fill_two();
    halt_req = 1; cycle();
    halt_req = 0;
    for (int k = 0; k < 2; k++) begin
      chk("hd_addr", {20'd0, imem_addr}, 40'd2);
      cycle();
    end
    out_ready = 1;
    cycle();
    chk("hd_not_halted", {39'd0, halted}, 40'd0);
    cycle();
    chk("hd_halted", {39'd0, halted}, 40'd1);
    chk("hd_addr_frz", {20'd0, imem_addr}, 40'd2);
    chk("hd_fcnt", {24'd0, fetch_count}, 40'd2);
    start = 1; cycle();
    start = 0; cycle();
    chk("hd_resume", {out_pc, out_inst}, {20'd2, 20'd2});

    // 5. Mid-run reset
    fill_two();
    rst = 1; cycle();
    rst = 0;
    chk("mr_valid", {39'd0, out_valid}, 40'd0);
    chk("mr_pc", {20'd0, out_pc}, 40'd0);
    chk("mr_addr", {20'd0, imem_addr}, 40'd0);
    chk("mr_fcnt", {24'd0, fetch_count}, 40'd0);
    for (int k = 0; k < 3; k++) cycle();
    chk("mr_nofetch", {20'd0, imem_addr}, 40'd0);

    // 6. Wrap
    do_reset();
    start = 1; out_ready = 1; cycle();
    start = 0; cycle();
    redirect_valid = 1; redirect_pc = 20'hFFFFF; cycle();
    redirect_valid = 0; cycle();
    chk("wr_0", {20'd0, out_pc}, 40'hFFFFF);
    cycle();
    chk("wr_1", {20'd0, out_pc}, 40'h00000);
    cycle();
    chk("wr_2", {20'd0, out_pc}, 40'h00001);

    // Random traffic
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      rst            = ($urandom_range(0, 149) == 0);
      start          = ($urandom_range(0, 5) == 0);
      halt_req       = ($urandom_range(0, 19) == 0);
      redirect_valid = ($urandom_range(0, 15) == 0);
      redirect_pc    = ($urandom_range(0, 2) == 0) ? 20'hFFFFE + 20'($urandom_range(0, 1))
                                                   : 20'($urandom);
      out_ready      = ($urandom_range(0, 3) != 0);
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Instruction fetch controller that sequences the combinational instruction memory: 20-bit address out, 20-bit instruction back in the same cycle.
- Owns the program counter (PC) and buffers fetched instructions in a 2-entry FIFO.
- Presents instructions to decode over a valid/ready handshake.
- Handles start, halt and PC redirect (branch/jump) with queue flush.

Parameters:
- ADDR_W, 20, PC and memory address width.
- INST_W, 20, instruction width.
- RESET_PC, 0, PC value loaded on reset.

Ports:
- clk  input  1  single clock, all state on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  begin/resume fetching (sampled in IDLE and HALTED).
- halt_req  input  1  stop fetching, drain queue, then halt.
- redirect_valid  input  1  load redirect_pc and flush queue.
- redirect_pc  input  ADDR_W  new PC.
- imem_addr  output  ADDR_W  instruction memory address; equals PC register, combinational.
- imem_inst  input  INST_W  instruction memory read data; valid in the same cycle.
- out_valid  output  1  head entry available.
- out_ready  input  1  decode accepts head.
- out_inst  output  INST_W  head instruction.
- out_pc  output  ADDR_W  PC of head instruction.
- halted  output  1  high in HALTED state.
- fetch_count  output  16  number of pushes since reset, saturating at 0xFFFF.

Behaviour:
- Reset: the synchronous rst, active-high, wins over every other input. On the edge where rst is sampled high:
  - state=IDLE, PC=RESET_PC, queue count=0;
  - head/tail entries cleared to 0, so out_inst=0 and out_pc=0;
  - out_valid=0, halted=0, fetch_count=0.
  - Reset in any state, including mid-fetch, discards all queued entries.
- States:
  - IDLE: no fetch. start → RUN.
  - RUN: fetch. halt_req (without redirect) → DRAIN.
  - DRAIN: no fetch. Queue empty at end of cycle → HALTED.
  - HALTED: halted=1, no fetch. start → RUN, with PC continuing from its held value.
- Fetch (RUN only):
  - A push occurs when count<2, or count==2 with a pop in the same cycle.
  - Push writes {PC, imem_inst} to the tail, and PC<=PC+1 modulo 2^ADDR_W (0xFFFFF wraps to 0x00000).
  - No push means PC and imem_addr hold.
  - halt_req sampled in RUN suppresses that cycle's push.
- Handshake:
  - out_valid = (count>0) & ~redirect_valid.
  - A pop occurs when out_valid & out_ready. The head advances, and the second entry becomes the head next cycle.
  - out_inst and out_pc are stable while out_valid=1 and out_ready=0.
- Latency: start sampled at edge N puts the state in RUN after N. The first push happens at edge N+1, and out_valid=1 after N+1. With out_ready held high, one instruction transfers per cycle.
- Redirect:
  - Priority is rst > redirect > halt_req > start.
  - In any state: PC<=redirect_pc, count<=0, no push and no pop that cycle. out_valid is forced to 0 that cycle.
  - State effects:
    - RUN stays RUN; fetch from redirect_pc starts the next cycle.
    - DRAIN → HALTED, because the queue is now empty.
    - IDLE and HALTED stay put, with PC updated.
- fetch_count increments by 1 per push and saturates at 0xFFFF.
- Simultaneous push and pop at count==1 or count==2 leaves count unchanged, and FIFO order is preserved.

Test Plan:
1. Flow: memory model where address k returns k for k=0..7. rst, then start with out_ready=1. Required: out_valid rises 2 edges after start; (out_pc, out_inst) = (0,0),(1,1)…(7,7), one per cycle, no gaps or duplicates; fetch_count=8 after 8 transfers.
2. Backpressure: out_ready=0 after start. Required: exactly 2 pushes, then imem_addr holds at 2, with out_pc=0 and out_inst=0 stable. Raise out_ready: outputs 0,1,2,3 in order, with a push and pop in the same cycle.
3. Redirect: with queue full (out_pc=0), pulse redirect_valid with redirect_pc=16. Required: out_valid=0 that cycle, queue flushed, then head out_pc=16 with out_inst=0x08180 followed by out_pc=17 with out_inst=0x02CB2.
4. Halt/drain: in RUN with 2 queued entries and out_ready=0, pulse halt_req and hold out_ready=0 for 3 cycles, then 1. Required: no further pushes, imem_addr frozen, 2 entries popped, halted=1 the cycle after the queue empties. A later start resumes at the held PC.
5. Mid-run reset: rst during RUN with count=2. Required: after the edge, out_valid=0, out_pc=0, imem_addr=RESET_PC, state IDLE, fetch_count=0, and no fetch until start.
6. Wrap: redirect to 0xFFFFF in RUN with out_ready=1. Required: out_pc sequence 0xFFFFF, 0x00000, 0x00001.
